// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states and
// the helper that turns a size code into a byte count.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of bytes touched by an access of the given size (the lane-mask width).
  function automatic int unsigned size_bytes(input logic [1:0] size);
    int unsigned n;
    n = 32'd1;
    unique case (size)
      SZ_BYTE:  n = 32'd1;
      SZ_HALF:  n = 32'd2;
      SZ_WORD:  n = 32'd4;
      SZ_DWORD: n = 32'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// CPU request/response and data-bus signals of the memory access unit.
// master = the access unit (it masters the data bus), slave = CPU/bus environment.
interface mem_access_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_size;
  logic              cpu_sign;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_exc;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [BYTES-1:0]  bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_size, cpu_sign, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
    output cpu_ready, cpu_done, cpu_rdata, cpu_exc,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_size, cpu_sign, cpu_addr, cpu_wdata, bus_ack, bus_rdata,
    input  cpu_ready, cpu_done, cpu_rdata, cpu_exc,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

endinterface

// File: rtl/mem_lane_ext.sv
// Load lane extraction: shift the merged beat data down to the access offset,
// truncate to the access size and sign/zero extend. Purely combinational.
module mem_lane_ext
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2*DATA_W-1:0]          merged,
  input  logic [$clog2(DATA_W/8)-1:0]  ofs,
  input  logic [1:0]                   size,
  input  logic                         sign,
  output logic [DATA_W-1:0]            result
);
  localparam int unsigned IDX_W = $clog2(DATA_W);

  int unsigned       nbits;
  logic [IDX_W-1:0]  msb_idx;
  logic [DATA_W-1:0] low;
  logic [DATA_W-1:0] fill;

  // fill marks the bits above the loaded field; they take the sign or zero.
  always_comb begin
    nbits = 32'd8 * size_bytes(size);
    if (nbits > DATA_W) nbits = DATA_W;
    low     = DATA_W'(merged >> {ofs, 3'b000});
    fill    = ~((DATA_W'(1) << nbits) - DATA_W'(1));
    msb_idx = IDX_W'(nbits - 32'd1);
    result  = (sign && low[msb_idx]) ? (low | fill) : (low & ~fill);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one CPU load/store -> one or two aligned bus beats.
// Optional feature macro: MISALIGN_SPLIT_EN (misaligned accesses split instead of trapping).
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic          clk,
  input logic          reset_n,
  mem_access_if.master io
);
  localparam int unsigned BYTES   = DATA_W / 8;
  localparam int unsigned OFS_W   = $clog2(BYTES);
`ifdef MISALIGN_SPLIT_EN
  localparam int unsigned SPAN    = 2;
`else
  localparam int unsigned SPAN    = 1;
`endif
  localparam int unsigned MASK_W  = SPAN * BYTES;
  localparam int unsigned WIDE_W  = SPAN * DATA_W;
  localparam int unsigned MERGE_W = 2 * DATA_W;

  state_t            state, state_n;
  logic              ready_q, ready_n, done_q, done_n, exc_q, exc_n, err_q, err_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              breq_q, breq_n, bwe_q, bwe_n;
  logic [ADDR_W-1:0] baddr_q, baddr_n;
  logic [BYTES-1:0]  bbe_q, bbe_n;
  logic [DATA_W-1:0] bwdata_q, bwdata_n;
  logic              we_q, we_n, sign_q, sign_n;
  logic [1:0]        size_q, size_n;
  logic [OFS_W-1:0]  ofs_q, ofs_n;
  logic [WIDE_W-1:0] merge_q, merge_n;
`ifdef MISALIGN_SPLIT_EN
  logic [BYTES-1:0]  be1_q, be1_n;
  logic [DATA_W-1:0] wdata1_q, wdata1_n;
`endif

  logic [OFS_W-1:0]   req_ofs;
  int unsigned        req_bytes;
  logic [MASK_W-1:0]  req_mask;
  logic [WIDE_W-1:0]  req_wide;
  logic               illegal;
  logic [MERGE_W-1:0] merge_full;
  logic [DATA_W-1:0]  load_data;

  // Request decode: lane mask, shifted store data and legality of the incoming access.
  always_comb begin
    req_ofs   = io.cpu_addr[OFS_W-1:0];
    req_bytes = size_bytes(io.cpu_size);
    req_mask  = ((MASK_W'(1) << req_bytes) - MASK_W'(1)) << req_ofs;
    req_wide  = WIDE_W'(io.cpu_wdata) << {req_ofs, 3'b000};
    illegal   = (req_bytes > BYTES);
`ifndef MISALIGN_SPLIT_EN
    if ((io.cpu_addr & ADDR_W'(req_bytes - 32'd1)) != '0) illegal = 1'b1;
`endif
  end

  assign merge_full = MERGE_W'(merge_q);

  mem_lane_ext #(.DATA_W(DATA_W)) u_lane_ext (
    .merged (merge_full),
    .ofs    (ofs_q),
    .size   (size_q),
    .sign   (sign_q),
    .result (load_data)
  );

  always_comb begin
    state_n  = state;
    ready_n  = ready_q;
    done_n   = 1'b0;
    exc_n    = 1'b0;
    rdata_n  = '0;
    err_n    = err_q;
    breq_n   = breq_q;
    bwe_n    = bwe_q;
    baddr_n  = baddr_q;
    bbe_n    = bbe_q;
    bwdata_n = bwdata_q;
    we_n     = we_q;
    size_n   = size_q;
    sign_n   = sign_q;
    ofs_n    = ofs_q;
    merge_n  = merge_q;
`ifdef MISALIGN_SPLIT_EN
    be1_n    = be1_q;
    wdata1_n = wdata1_q;
`endif
    unique case (state)
      IDLE: begin
        // The cycle after DONE still reports busy; ready comes back one cycle later.
        if (!ready_q) begin
          ready_n = 1'b1;
        end else if (io.cpu_req) begin
          ready_n = 1'b0;
          we_n    = io.cpu_we;
          size_n  = io.cpu_size;
          sign_n  = io.cpu_sign;
          ofs_n   = req_ofs;
          merge_n = '0;
          err_n   = illegal;
          if (illegal) begin
            state_n = DONE;
          end else begin
            state_n  = BEAT0;
            breq_n   = 1'b1;
            bwe_n    = io.cpu_we;
            baddr_n  = io.cpu_addr & ~ADDR_W'(BYTES - 1);
            bbe_n    = req_mask[BYTES-1:0];
            bwdata_n = req_wide[DATA_W-1:0];
`ifdef MISALIGN_SPLIT_EN
            be1_n    = req_mask[MASK_W-1:BYTES];
            wdata1_n = req_wide[WIDE_W-1:DATA_W];
`endif
          end
        end
      end
      BEAT0: begin
        if (io.bus_ack) begin
          merge_n[DATA_W-1:0] = io.bus_rdata;
          state_n = DONE;
          breq_n  = 1'b0;
`ifdef MISALIGN_SPLIT_EN
          if (be1_q != '0) begin
            state_n  = BEAT1;
            breq_n   = 1'b1;
            baddr_n  = baddr_q + ADDR_W'(BYTES);
            bbe_n    = be1_q;
            bwdata_n = wdata1_q;
          end
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      BEAT1: begin
        if (io.bus_ack) begin
          merge_n[WIDE_W-1:DATA_W] = io.bus_rdata;
          state_n = DONE;
          breq_n  = 1'b0;
        end
      end
`endif
      DONE: begin
        done_n  = 1'b1;
        exc_n   = err_q;
        rdata_n = (we_q || err_q) ? '0 : load_data;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      exc_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      breq_q   <= 1'b0;
      bwe_q    <= 1'b0;
      baddr_q  <= '0;
      bbe_q    <= '0;
      bwdata_q <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      sign_q   <= 1'b0;
      ofs_q    <= '0;
      merge_q  <= '0;
`ifdef MISALIGN_SPLIT_EN
      be1_q    <= '0;
      wdata1_q <= '0;
`endif
    end else begin
      state    <= state_n;
      ready_q  <= ready_n;
      done_q   <= done_n;
      exc_q    <= exc_n;
      err_q    <= err_n;
      rdata_q  <= rdata_n;
      breq_q   <= breq_n;
      bwe_q    <= bwe_n;
      baddr_q  <= baddr_n;
      bbe_q    <= bbe_n;
      bwdata_q <= bwdata_n;
      we_q     <= we_n;
      size_q   <= size_n;
      sign_q   <= sign_n;
      ofs_q    <= ofs_n;
      merge_q  <= merge_n;
`ifdef MISALIGN_SPLIT_EN
      be1_q    <= be1_n;
      wdata1_q <= wdata1_n;
`endif
    end
  end

  assign io.cpu_ready = ready_q;
  assign io.cpu_done  = done_q;
  assign io.cpu_rdata = rdata_q;
  assign io.cpu_exc   = exc_q;
  assign io.bus_req   = breq_q;
  assign io.bus_we    = bwe_q;
  assign io.bus_addr  = baddr_q;
  assign io.bus_be    = bbe_q;
  assign io.bus_wdata = bwdata_q;

endmodule
